alu_8bit_ctrl: RTL and testbench
================================

# alu_8bit_ctrl

Sequencing controller for the 8-bit ALU datapath. It accepts one operation at a time (opcode plus two 8-bit operands) over a valid/ready handshake. It executes single-cycle logic and arithmetic ops directly and runs shifts and multiply as multi-cycle iterative sequences. It returns a registered result with carry/zero flags over a second valid/ready handshake. It sits between the instruction/test front end and the combinational AND/OR/XOR/ADD units.

## Interface
Parameters:
- WIDTH, 8, operand/result width; only 8 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request present
- in_ready  out  1  controller can accept an operation
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- a  in  8  operand A
- b  in  8  operand B; for SHL/SHR only b[2:0] is used as the shift count
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- result  out  8  registered result
- carry  out  1  carry/borrow/shift-out/overflow flag
- zero  out  1  1 when result == 0
- err  out  1  unsupported opcode (only possible when MUL is compiled out)

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture op, a, b and count=b[2:0], then go to EXEC.
- EXEC, ops 000–100: one cycle, then DONE.
  - ADD: result=a+b; carry=bit 8 of the sum.
  - SUB: result=a-b mod 256; carry=1 when a<b (borrow).
  - AND/OR/XOR: bitwise result; carry=0.
- EXEC, SHL/SHR: one bit per cycle for count cycles; count=0 takes one cycle and leaves the value unchanged.
  - Zero-fill on every step.
  - carry = last bit shifted out; 0 when count=0.
- EXEC, MUL: shift-add over exactly 8 cycles on a 16-bit accumulator.
  - result = product[7:0].
  - carry=1 when product[15:8]!=0.
- DONE:
  - out_valid=1. result, carry, zero and err are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- in_ready=0 in EXEC and DONE. A request is never dropped: in_valid is simply not acknowledged.
- zero is computed from the final result and is registered together with it.
- Reset values: state=IDLE; result=8'h00; carry=0; zero=0; err=0; out_valid=0; in_ready=0 while rst=1.
- Reset mid-operation, in EXEC or DONE: the operation is abandoned with no output handshake. The controller is in IDLE on the first cycle after rst deasserts.

## Timing
- Accept handshake in cycle N; EXEC starts in cycle N+1.
- out_valid first rises in:
  - ops 000–100: cycle N+2.
  - SHL/SHR with count k≥1: cycle N+1+k.
  - SHL/SHR with count 0: cycle N+2.
  - MUL: cycle N+9.
- Output handshake in cycle M: in_ready=1 in cycle M+1. No same-cycle accept/complete overlap, so throughput is at most one op every 3 cycles.
- out_ready held low: the controller stays in DONE indefinitely with outputs stable.
- out_ready high before out_valid has no effect.

## Configuration
- ALU_CTRL_MUL_EN defined:
  - op 111 performs the 8-cycle MUL.
  - err is tied to 0.
- ALU_CTRL_MUL_EN undefined:
  - Multiplier logic is absent.
  - op 111 spends one EXEC cycle and completes with result=8'h00, carry=0, zero=1, err=1.
  - err is 0 for every other op.

## Structure
- Package alu_ctrl_pkg holds:
  - opcode localparams (OP_ADD … OP_MUL);
  - state encoding (ST_IDLE, ST_EXEC, ST_DONE);
  - the width constant.
- Sub-module alu_iter_unit: the iterative shift/multiply datapath.
  - Inputs: start/step enables, operands, direction.
  - Outputs: value and carry, 16-bit accumulator internal.
  - Its MUL portion is wrapped in ALU_CTRL_MUL_EN.
- The FSM, handshake logic and single-cycle ops stay in alu_8bit_ctrl.

## Test plan
- ADD a=8'hF0, b=8'h20, out_ready=1 -> out_valid at N+2; result=8'h10, carry=1, zero=0.
- SUB a=8'h05, b=8'h05, then XOR a=8'hAA, b=8'hFF -> 8'h00 with carry=0, zero=1; then 8'h55 with carry=0, zero=0. in_ready stays 0 between accept and output handshake.
- SHL a=8'h81, b=8'h03 -> out_valid at N+4, result=8'h08, carry=0. SHR a=8'h81, b=8'h00 -> N+2, result=8'h81, carry=0.
- MUL a=8'h10, b=8'h11 -> out_valid at N+9, result=8'h10, carry=1. With the macro undefined, the same op -> N+2, result=8'h00, err=1, zero=1.
- Hold out_ready=0 for 5 cycles after OR a=8'h0F, b=8'hF0 -> result=8'hFF held stable, in_valid ignored; release -> in_ready=1 the next cycle.
- Assert rst for 1 cycle during cycle 4 of a MUL -> no out_valid. All outputs are at reset values, and in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants for the 8-bit ALU sequencing controller
package alu_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 2 * DATA_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - iterative shift / shift-add multiply datapath
// Multiplier portion present only when ALU_CTRL_MUL_EN is defined.
module alu_iter_unit
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              dir,
`ifdef ALU_CTRL_MUL_EN
    input  logic              mul,
    input  logic [DATA_W-1:0] b,
`endif
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] value,
    output logic              carry
);

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_nxt;
    logic              sh_out;
    logic              cy_q;

    always_comb begin
        sh_nxt = dir ? {1'b0, sh_q[DATA_W-1:1]} : {sh_q[DATA_W-2:0], 1'b0};
        sh_out = dir ? sh_q[0] : sh_q[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
            cy_q <= 1'b0;
        end else if (start) begin
            sh_q <= a;
            cy_q <= 1'b0;
        end else if (step) begin
            sh_q <= sh_nxt;
            cy_q <= sh_out;
        end
    end

`ifdef ALU_CTRL_MUL_EN
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  acc_view;

    assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign acc_view = step ? acc_nxt : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a};
            mplier_q <= b;
        end else if (step) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`endif

    // Outputs reflect the value after this cycle's step so the controller
    // can register the final result on the same edge as the last step.
    always_comb begin
        value = step ? sh_nxt : sh_q;
        carry = step ? sh_out : cy_q;
`ifdef ALU_CTRL_MUL_EN
        if (mul) begin
            value = acc_view[DATA_W-1:0];
            carry = |acc_view[ACC_W-1:DATA_W];
        end
`endif
    end

endmodule

// File: rtl/alu_8bit_ctrl.sv
// rtl/alu_8bit_ctrl.sv - ALU sequencing controller with valid/ready in/out handshakes
// ALU_CTRL_MUL_EN enables the 8-cycle multiply; otherwise op 111 reports err.
module alu_8bit_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    logic [1:0]       state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             err_q;

    logic             accept;
    logic             complete;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             iter_step;
    logic [WIDTH-1:0] iter_value;
    logic             iter_carry;
    logic             exec_last;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cy;
    logic             fin_err;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE) && !rst;
    assign accept    = in_valid && in_ready;
    assign complete  = out_valid && out_ready;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

    alu_iter_unit u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .step  (iter_step),
        .dir   (op_q == OP_SHR),
`ifdef ALU_CTRL_MUL_EN
        .mul   (op_q == OP_MUL),
        .b     (b),
`endif
        .a     (a),
        .value (iter_value),
        .carry (iter_carry)
    );

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        exec_last = 1'b1;
        fin_res   = '0;
        fin_cy    = 1'b0;
        fin_err   = 1'b0;
        iter_step = 1'b0;
        case (op_q)
            OP_ADD: begin
                fin_res = sum[WIDTH-1:0];
                fin_cy  = sum[WIDTH];
            end
            OP_SUB: begin
                fin_res = diff[WIDTH-1:0];
                fin_cy  = diff[WIDTH];
            end
            OP_AND: fin_res = a_q & b_q;
            OP_OR:  fin_res = a_q | b_q;
            OP_XOR: fin_res = a_q ^ b_q;
            OP_SHL, OP_SHR: begin
                // A zero count still spends one EXEC cycle without stepping.
                iter_step = (cnt_q != 3'd0);
                exec_last = (cnt_q <= 3'd1);
                fin_res   = iter_value;
                fin_cy    = iter_carry;
            end
            OP_MUL: begin
`ifdef ALU_CTRL_MUL_EN
                iter_step = 1'b1;
                exec_last = (cnt_q == 3'd0);
                fin_res   = iter_value;
                fin_cy    = iter_carry;
`else
                fin_err   = 1'b1;
`endif
            end
            default: ;
        endcase
        if (state_q != ST_EXEC) begin
            iter_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= 3'd0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= (op == OP_MUL) ? 3'd7 : b[2:0];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (iter_step) begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                    if (exec_last) begin
                        result_q <= fin_res;
                        carry_q  <= fin_cy;
                        zero_q   <= (fin_res == '0);
                        err_q    <= fin_err;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (complete) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_8bit_ctrl.sv
// tb/tb_alu_8bit_ctrl.sv - self-checking bench for alu_8bit_ctrl
module tb_alu_8bit_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cy;
        logic       z;
        logic       e;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    vec_t vecs[15];
    vec_t sb[$];

    alu_8bit_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual timeout required DUT response", name);
    endtask

    task automatic do_accept(input vec_t v, output bit ok, output int n);
        @(negedge clk);
        in_valid = 1'b1;
        op = v.op;
        a  = v.a;
        b  = v.b;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n = cyc;
        if (ok) sb.push_back(v);
        else timeout("accept");
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = 8'($urandom);
        b  = 8'($urandom);
    endtask

    task automatic do_wait(output bit ok, output logic busy);
        ok   = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            busy |= in_ready;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("out_valid");
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit   ok;
        int   n;
        logic busy;
        vec_t e;
        out_ready = 1'b1;
        do_accept(v, ok, n);
        if (!ok) return;
        do_wait(ok, busy);
        e = sb.pop_front();
        if (!ok) return;
        check($sformatf("%s latency", tag), cyc - n, e.lat);
        check($sformatf("%s result", tag), result, e.res);
        check($sformatf("%s carry", tag), carry, e.cy);
        check($sformatf("%s zero", tag), zero, e.z);
        check($sformatf("%s err", tag), err, e.e);
        check($sformatf("%s in_ready_busy", tag), busy, 0);
        @(negedge clk);
        check($sformatf("%s in_ready_after", tag), in_ready, 1);
        check($sformatf("%s out_valid_after", tag), out_valid, 0);
    endtask

    initial begin
        bit   ok;
        int   n;
        logic busy;
        logic seen;
        vec_t e;
        vec_t hv;
        vec_t lv;

        vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 2};
        vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 2};
        vecs[2]  = '{OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{OP_SHL, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4};
        vecs[4]  = '{OP_SHR, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 2};
`ifdef ALU_CTRL_MUL_EN
        vecs[5]  = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 9};
        vecs[11] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 9};
        vecs[12] = '{OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0, 9};
        lv       = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 9};
`else
        vecs[5]  = '{OP_MUL, 8'h10, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1, 2};
        vecs[11] = '{OP_MUL, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 2};
        vecs[12] = '{OP_MUL, 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 2};
        lv       = '{OP_SHL, 8'hA5, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8};
`endif
        vecs[6]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 2};
        vecs[7]  = '{OP_SHR, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 2};
        vecs[8]  = '{OP_SHL, 8'hA5, 8'h06, 8'h40, 1'b1, 1'b0, 1'b0, 7};
        vecs[9]  = '{OP_AND, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 2};
        vecs[13] = '{OP_OR,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2};
        vecs[14] = '{OP_SHR, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 8};
        hv       = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 2};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'd0;
        a = 8'd0;
        b = 8'd0;
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset carry", carry, 0);
        check("reset zero", zero, 0);
        check("reset err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Output stall: result must hold and new requests must not be taken.
        out_ready = 1'b0;
        do_accept(hv, ok, n);
        in_valid = 1'b1;
        op = OP_ADD;
        a = 8'h01;
        b = 8'h01;
        if (ok) begin
            do_wait(ok, busy);
            e = sb.pop_front();
            if (ok) begin
                check("hold latency", cyc - n, e.lat);
                check("hold carry", carry, e.cy);
                check("hold zero", zero, e.z);
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("hold result c%0d", i), result, e.res);
                    check($sformatf("hold out_valid c%0d", i), out_valid, 1);
                    check($sformatf("hold in_ready c%0d", i), in_ready, 0);
                    @(negedge clk);
                end
                check("hold still valid", out_valid, 1);
                out_ready = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check("hold release in_ready", in_ready, 1);
                check("hold release out_valid", out_valid, 0);
            end
        end
        in_valid = 1'b0;

        run_vec(vecs[6], "pre_reset");

        // Reset in the fourth EXEC cycle of a long operation.
        do_accept(lv, ok, n);
        if (ok) e = sb.pop_back();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst in_ready", in_ready, 0);
        check("midrst out_valid", out_valid, 0);
        check("midrst result", result, 0);
        check("midrst carry", carry, 0);
        check("midrst zero", zero, 0);
        check("midrst err", err, 0);
        rst = 1'b0;
        #1;
        check("midrst in_ready_after", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("midrst no out_valid", seen, 0);

        run_vec(vecs[0], "post_reset");

        check("scoreboard empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
